// File: rtl/cla_pkg.sv
// Shared types and helpers for the chunked carry-lookahead adder.
// Holds the sequencer state encoding and the slice-index width helper.
package cla_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } cla_seq_state_t;

  // Index counter width; a single-slice case still needs one bit.
  function automatic int idx_width(input int words);
    return (words > 1) ? $clog2(words) : 1;
  endfunction

endpackage

// File: rtl/cla.sv
// Combinational carry-lookahead adder without carry-in.
// o_z holds the WIDTH-bit sum with the carry-out in its MSB.
module cla #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic [WIDTH:0]   o_z
);

  logic [WIDTH-1:0] w_g;
  logic [WIDTH-1:0] w_p;
  logic [WIDTH:0]   w_c;

  assign w_g = i_a & i_b;
  assign w_p = i_a ^ i_b;

  // Each carry is the flattened sum of products g[j] & p[j+1..i], no ripple chain.
  always_comb begin
    logic w_term;
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
    w_term = 1'b0;
    w_c    = '0;
    for (int i = 0; i < WIDTH; i++) begin
      for (int j = 0; j <= i; j++) begin
        w_term = w_g[j];
        for (int k = j + 1; k <= i; k++) begin
          w_term = w_term & w_p[k];
        end
        w_c[i+1] = w_c[i+1] | w_term;
      end
    end
  end

  assign o_z = {w_c[WIDTH], w_p ^ w_c[WIDTH-1:0]};

endmodule

// File: rtl/cla_chunk_seq.sv
// Multi-cycle wide adder: streams CHUNK-bit slices, LSB first, through one shared cla,
// chaining the carry in a register. Valid/ready handshake on both sides.
module cla_chunk_seq
  import cla_pkg::*;
#(
  parameter int CHUNK = 4,
  parameter int WORDS = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [CHUNK*WORDS-1:0] a,
  input  logic [CHUNK*WORDS-1:0] b,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [CHUNK*WORDS:0]   sum
);

  localparam int W  = CHUNK * WORDS;
  localparam int IW = idx_width(WORDS);

  cla_seq_state_t r_state;
  logic [W-1:0]   r_a;
  logic [W-1:0]   r_b;
  logic [W:0]     r_sum;
  logic           r_carry;
  logic [IW-1:0]  r_idx;
  logic           r_in_ready;
  logic           r_out_valid;

  logic [CHUNK+1:0] w_z;
  logic [CHUNK-1:0] w_slice;
  logic             w_cout;
  logic             w_unused_z0;

  // Forcing the low operand bit to 1 turns the no-carry-in cla into one with carry-in r_carry.
  cla #(.WIDTH(CHUNK + 1)) u_cla (
    .i_a({r_a[CHUNK-1:0], 1'b1}),
    .i_b({r_b[CHUNK-1:0], r_carry}),
    .o_z(w_z)
  );

  assign w_slice     = w_z[CHUNK:1];
  assign w_cout      = w_z[CHUNK+1];
  assign w_unused_z0 = w_z[0];

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_a         <= '0;
      r_b         <= '0;
      r_sum       <= '0;
      r_carry     <= 1'b0;
      r_idx       <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_a        <= a;
            r_b        <= b;
            r_sum      <= '0;
            r_carry    <= 1'b0;
            r_idx      <= '0;
            r_in_ready <= 1'b0;
            r_state    <= RUN;
          end
        end
        RUN: begin
          r_a              <= r_a >> CHUNK;
          r_b              <= r_b >> CHUNK;
          r_sum[W-1:0]     <= {w_slice, r_sum[W-1:CHUNK]};
          r_carry          <= w_cout;
          r_idx            <= r_idx + IW'(1);
          if (r_idx == IW'(WORDS - 1)) begin
            r_sum[W]    <= w_cout;
            r_out_valid <= 1'b1;
            r_state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= IDLE;
          end
        end
        default: begin
          r_in_ready  <= 1'b1;
          r_out_valid <= 1'b0;
          r_state     <= IDLE;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign sum       = r_sum;

`ifdef FORMAL
  logic [W-1:0] r_a_acc;
  logic [W-1:0] r_b_acc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a_acc <= '0;
      r_b_acc <= '0;
    end else if (r_state == IDLE && in_valid) begin
      r_a_acc <= a;
      r_b_acc <= b;
    end
  end

  always_comb begin
    if (!rst && r_out_valid) assert (r_sum == ({1'b0, r_a_acc} + {1'b0, r_b_acc}));
    if (!rst) assert (r_in_ready == (r_state == IDLE));
  end
`endif

endmodule

// File: tb/tb_cla_chunk_seq.sv
// Scoreboard bench for cla_chunk_seq at CHUNK=4, WORDS=4: expected sums are queued at
// the accepting edge and compared at each output handshake.
module tb_cla_chunk_seq;

  localparam int CHUNK = 4;
  localparam int WORDS = 4;
  localparam int W     = CHUNK * WORDS;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         out_valid;
  logic         out_ready;
  logic [W:0]   sum;

  cla_chunk_seq #(.CHUNK(CHUNK), .WORDS(WORDS)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a        (a),
    .b        (b),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .sum      (sum)
  );

  int         n_total;
  int         n_bad;
  int         cyc;
  int         last_acc;
  int         prev_acc;
  int         rdy_mode;
  bit         prev_ov;
  bit         ho_pending;
  logic [W:0] sb[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // out_ready: 0 = always ready, 1 = never ready, 2 = random stalls.
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0:       out_ready = 1'b1;
        1:       out_ready = 1'b0;
        default: out_ready = ($urandom_range(0, 3) != 0);
      endcase
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      sb.delete();
      prev_ov    = 1'b0;
      ho_pending = 1'b0;
    end else begin
      if (ho_pending) begin
        check("idle_in_ready", {31'd0, in_ready}, 32'd1);
        check("idle_out_valid", {31'd0, out_valid}, 32'd0);
        ho_pending = 1'b0;
      end
      if (out_valid && !prev_ov) check("latency", cyc - last_acc, WORDS);
      if (out_valid && out_ready) begin
        if (sb.size() == 0) check("dup_result", {31'd0, out_valid}, 32'd0);
        else check("sum", {15'd0, sum}, {15'd0, sb.pop_front()});
        ho_pending = 1'b1;
      end
      if (in_valid && in_ready) begin
        sb.push_back({1'b0, a} + {1'b0, b});
        prev_acc = last_acc;
        last_acc = cyc + 1;
      end
      prev_ov = out_valid;
    end
  end

  task automatic send(input logic [W-1:0] va, input logic [W-1:0] vb, input bit hold);
    int n;
    n        = 0;
    a        = va;
    b        = vb;
    in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) check("accept_timeout", {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    #1;
    if (!hold) in_valid = 1'b0;
    a = W'($urandom);
    b = W'($urandom);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((sb.size() != 0 || out_valid) && n < 500) begin
      @(negedge clk);
      n++;
    end
    check("drain", sb.size(), 0);
    @(posedge clk);
    #1;
  endtask

  task automatic wait_out_valid();
    int n;
    n = 0;
    while (!out_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("out_valid_timeout", {31'd0, out_valid}, 32'd1);
  endtask

  initial begin
    logic [W:0]   held;
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    n_total    = 0;
    n_bad      = 0;
    cyc        = 0;
    last_acc   = 0;
    prev_acc   = 0;
    rdy_mode   = 0;
    prev_ov    = 1'b0;
    ho_pending = 1'b0;
    rst        = 1'b1;
    in_valid   = 1'b0;
    a          = '0;
    b          = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_sum", {15'd0, sum}, 32'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Basic operation and carry ripple cases
    send(16'h1234, 16'h4321, 1'b0);
    drain();
    send(16'hFFFF, 16'h0001, 1'b0);
    drain();
    send(16'hFFFF, 16'hFFFF, 1'b0);
    drain();
    send(16'h0000, 16'h0000, 1'b0);
    drain();

    // Reset mid-run discards the op; next op must see no stale carry
    send(16'hFFFF, 16'hFFFF, 1'b0);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("midrun_in_ready", {31'd0, in_ready}, 32'd1);
    check("midrun_out_valid", {31'd0, out_valid}, 32'd0);
    check("midrun_sum", {15'd0, sum}, 32'd0);
    @(negedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    send(16'h0003, 16'h0004, 1'b0);
    drain();

    // Backpressure: result held, inputs ignored
    rdy_mode  = 1;
    out_ready = 1'b0;
    send(16'hA5A5, 16'h5A5B, 1'b0);
    wait_out_valid();
    held = sum;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      in_valid = ~in_valid;
      a        = W'($urandom);
      b        = W'($urandom);
      @(negedge clk);
      check("bp_sum", {15'd0, sum}, {15'd0, held});
      check("bp_in_ready", {31'd0, in_ready}, 32'd0);
      check("bp_out_valid", {31'd0, out_valid}, 32'd1);
    end
    in_valid = 1'b0;
    rdy_mode = 0;
    drain();
    repeat (3) @(negedge clk);
    check("bp_no_extra", {31'd0, out_valid}, 32'd0);

    // Operand isolation: a/b churn after acceptance
    send(16'h0F0F, 16'h7070, 1'b0);
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1;
      a = W'($urandom);
      b = W'($urandom);
    end
    drain();

    // Back-to-back with in_valid held: second op accepted in first IDLE cycle
    send(16'h1111, 16'h2222, 1'b1);
    send(16'h00FF, 16'h0F01, 1'b0);
    check("b2b_interval", last_acc - prev_acc, WORDS + 2);
    drain();

    // Random operands with random output stalls
    rdy_mode = 2;
    for (int i = 0; i < 2000; i++) begin
      case ($urandom_range(0, 5))
        0:       ra = 16'hFFFF;
        1:       ra = 16'h0000;
        default: ra = W'($urandom);
      endcase
      case ($urandom_range(0, 5))
        0:       rb = 16'hFFFF;
        1:       rb = 16'h0001;
        default: rb = W'($urandom);
      endcase
      send(ra, rb, 1'b0);
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end
    drain();
    rdy_mode = 0;
    repeat (3) @(negedge clk);
    check("final_out_valid", {31'd0, out_valid}, 32'd0);
    check("sb_empty", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
